// File: rtl/bcd_add_control.sv
// bcd_add_control: steps a BCD adder datapath through load/display operations,
// one four-phase request/ack handshake per debounced-free next_btn press.
//
// Optional feature macro: BCD_CTRL_TIMEOUT_EN (ack timeout counter + sticky err).
//
// Ports:
//   CLK, RESET_N          clock, synchronous active-low reset
//   next_btn              raw asynchronous pushbutton
//   *_ack                 acks from bcd_add_datapath (six, one per step)
//   load_a .. display_ms  registered requests to bcd_add_datapath
//   step[2:0]             current step index 0..5
//   busy                  high whenever the FSM is not IDLE
//   err                   sticky ack-timeout flag (0 when timeout disabled)
module bcd_add_control #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       next_btn,
    input  logic       load_a_ack,
    input  logic       load_b_ack,
    input  logic       display_a_ack,
    input  logic       display_b_ack,
    input  logic       display_ls_ack,
    input  logic       display_ms_ack,
    output logic       load_a,
    output logic       load_b,
    output logic       display_a,
    output logic       display_b,
    output logic       display_ls,
    output logic       display_ms,
    output logic [2:0] step,
    output logic       busy,
    output logic       err
);

    localparam int unsigned N_STEPS = 6;
    localparam int unsigned STEP_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Elaboration guard: a zero timeout would fire before any ack could arrive
    if (ACK_TIMEOUT == 0) begin : g_bad_ack_timeout
        $error("bcd_add_control: ACK_TIMEOUT must be at least 1");
    end

    state_t              state;
    logic [N_STEPS-1:0]  req_q;
    logic                btn_sync1;
    logic                btn_sync2;
    logic                btn_prev;
    logic                btn_rise_c;
    logic                sel_ack_c;

`ifdef BCD_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit_c;
    assign tmo_hit_c = (tmo_cnt == CNT_W'(ACK_TIMEOUT));
`endif

    // Button synchronizer and edge register; reset high so a held button is not a press
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            btn_sync1 <= 1'b1;
            btn_sync2 <= 1'b1;
            btn_prev  <= 1'b1;
        end else begin
            btn_sync1 <= next_btn;
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_sync2;
        end
    end

    assign btn_rise_c = btn_sync2 & ~btn_prev;

    // Only the ack belonging to the current step is ever looked at
    always_comb begin
        sel_ack_c = 1'b0;
        case (step)
            3'd0:    sel_ack_c = load_a_ack;
            3'd1:    sel_ack_c = load_b_ack;
            3'd2:    sel_ack_c = display_a_ack;
            3'd3:    sel_ack_c = display_b_ack;
            3'd4:    sel_ack_c = display_ls_ack;
            3'd5:    sel_ack_c = display_ms_ack;
            default: sel_ack_c = 1'b0;
        endcase
    end

    // Handshake FSM with registered requests, step, busy and err
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            step  <= '0;
            req_q <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_CTRL_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (btn_rise_c) begin
                        state <= REQ;
                        req_q <= N_STEPS'(1) << step;
                        busy  <= 1'b1;
`ifdef BCD_CTRL_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    if (sel_ack_c) begin
                        state <= REL;
                        req_q <= '0;
`ifdef BCD_CTRL_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit_c) begin
                        state <= ERR;
                        req_q <= '0;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end
                REL: begin
                    if (!sel_ack_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        step  <= (step == STEP_W'(N_STEPS - 1)) ? '0 : step + STEP_W'(1);
`ifdef BCD_CTRL_TIMEOUT_EN
                    end else if (tmo_hit_c) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end
                ERR: begin
                    // Sticky until reset
                    req_q <= '0;
                end
                default: begin
                    state <= IDLE;
                    req_q <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign load_a     = req_q[0];
    assign load_b     = req_q[1];
    assign display_a  = req_q[2];
    assign display_b  = req_q[3];
    assign display_ls = req_q[4];
    assign display_ms = req_q[5];

endmodule

// File: tb/tb_bcd_add_control.sv
// tb_bcd_add_control: directed self-checking bench for bcd_add_control.
// Instantiates the controller with ACK_TIMEOUT=8; timeout expectations follow
// BCD_CTRL_TIMEOUT_EN.
module tb_bcd_add_control;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       next_btn;
    logic [5:0] ack;
    logic       load_a, load_b, display_a, display_b, display_ls, display_ms;
    logic [2:0] step;
    logic       busy;
    logic       err;
    logic [5:0] req;

    int checks   = 0;
    int failures = 0;

    bcd_add_control #(.ACK_TIMEOUT(8)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .next_btn       (next_btn),
        .load_a_ack     (ack[0]),
        .load_b_ack     (ack[1]),
        .display_a_ack  (ack[2]),
        .display_b_ack  (ack[3]),
        .display_ls_ack (ack[4]),
        .display_ms_ack (ack[5]),
        .load_a         (load_a),
        .load_b         (load_b),
        .display_a      (display_a),
        .display_b      (display_b),
        .display_ls     (display_ls),
        .display_ms     (display_ms),
        .step           (step),
        .busy           (busy),
        .err            (err)
    );

    assign req = {display_ms, display_ls, display_b, display_a, load_b, load_a};

    always #5 CLK = ~CLK;

    // Advance n rising edges, then settle 1 time unit before sampling
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick(2);
        RESET_N = 1'b1;
    endtask

    // Press the button; request must appear exactly on the 3rd edge. Returns one edge after.
    task automatic press(input string tag, input int idx);
        next_btn = 1'b1;
        tick(2);
        check($sformatf("%s_early", tag), 8'(req), 8'h00);
        tick(1);
        check($sformatf("%s_req", tag), 8'(req), 8'(6'd1 << idx));
        tick(1);
        next_btn = 1'b0;
    endtask

    task automatic wait_req_low(input string tag);
        int i;
        i = 0;
        while (req != 6'd0 && i < 20) begin
            tick(1);
            i++;
        end
        check(tag, 8'(req), 8'h00);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 20) begin
            tick(1);
            i++;
        end
        check(tag, 8'(busy), 8'h00);
    endtask

    // One complete handshake for step idx with a responsive datapath
    task automatic full_step(input int idx);
        press($sformatf("step%0d", idx), idx);
        ack[idx] = 1'b1;
        wait_req_low($sformatf("step%0d_rel", idx));
        ack[idx] = 1'b0;
        wait_idle($sformatf("step%0d_idle", idx));
        check($sformatf("step%0d_next", idx), 8'(step), 8'((idx + 1) % 6));
    endtask

    initial begin
        RESET_N  = 1'b0;
        next_btn = 1'b1;
        ack      = '0;

        // Reset state, button held through reset release
        tick(2);
        check("rst_req", 8'(req), 8'h00);
        check("rst_step", 8'(step), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_err", 8'(err), 8'h00);
        RESET_N = 1'b1;
        tick(20);
        check("held_req", 8'(req), 8'h00);
        check("held_step", 8'(step), 8'h00);
        check("held_busy", 8'(busy), 8'h00);
        next_btn = 1'b0;
        tick(5);
        check("release_busy", 8'(busy), 8'h00);

        // Single load_a handshake with exact latency
        next_btn = 1'b1;
        tick(1);
        check("lat_e1", 8'(req), 8'h00);
        tick(1);
        check("lat_e2", 8'(req), 8'h00);
        tick(1);
        check("lat_e3", 8'(req), 8'h01);
        check("lat_busy", 8'(busy), 8'h01);
        tick(1);
        next_btn = 1'b0;
        tick(1);
        ack[0] = 1'b1;
        tick(1);
        check("hs_rel_req", 8'(req), 8'h00);
        check("hs_rel_busy", 8'(busy), 8'h01);
        tick(2);
        ack[0] = 1'b0;
        check("hs_rel_step", 8'(step), 8'h00);
        tick(1);
        check("hs_done_busy", 8'(busy), 8'h00);
        check("hs_done_step", 8'(step), 8'h01);
        tick(5);
        check("hs_single_req", 8'(req), 8'h00);
        check("hs_single_step", 8'(step), 8'h01);

        // Full sequence with wrap
        do_reset();
        tick(4);
        for (int i = 0; i < 6; i++) full_step(i);

        // Step 2: foreign acks and a press during REQ are ignored
        full_step(0);
        full_step(1);
        press("ign", 2);
        ack[0] = 1'b1;
        tick(1);
        ack[5] = 1'b1;
        tick(1);
        ack[0] = 1'b0;
        ack[5] = 1'b0;
        tick(1);
        check("ign_req", 8'(req), 8'h04);
        check("ign_step", 8'(step), 8'h02);
        next_btn = 1'b1;
        tick(4);
        next_btn = 1'b0;
        tick(3);
        check("ign_press_req", 8'(req), 8'h04);
        ack[2] = 1'b1;
        wait_req_low("ign_rel");
        ack[2] = 1'b0;
        wait_idle("ign_idle");
        check("ign_step3", 8'(step), 8'h03);
        tick(10);
        check("ign_noqueue_req", 8'(req), 8'h00);
        check("ign_noqueue_step", 8'(step), 8'h03);
        check("ign_noqueue_busy", 8'(busy), 8'h00);

        // One-cycle reset while in REL at step 3
        press("rstrel", 3);
        ack[3] = 1'b1;
        tick(1);
        check("rstrel_inrel_req", 8'(req), 8'h00);
        check("rstrel_inrel_busy", 8'(busy), 8'h01);
        RESET_N = 1'b0;
        tick(1);
        RESET_N = 1'b1;
        check("rstrel_req", 8'(req), 8'h00);
        check("rstrel_step", 8'(step), 8'h00);
        check("rstrel_busy", 8'(busy), 8'h00);
        ack[3] = 1'b0;
        tick(5);
        check("rstrel_after_busy", 8'(busy), 8'h00);
        check("rstrel_after_step", 8'(step), 8'h00);

        // Ack never raised
        press("tmo", 0);
        tick(4);
        check("tmo_early_err", 8'(err), 8'h00);
        check("tmo_early_req", 8'(req), 8'h01);
`ifdef BCD_CTRL_TIMEOUT_EN
        tick(7);
        check("tmo_err", 8'(err), 8'h01);
        check("tmo_req", 8'(req), 8'h00);
        check("tmo_busy", 8'(busy), 8'h01);
        next_btn = 1'b1;
        tick(4);
        next_btn = 1'b0;
        tick(5);
        check("tmo_press_req", 8'(req), 8'h00);
        check("tmo_press_err", 8'(err), 8'h01);
        check("tmo_step", 8'(step), 8'h00);
        do_reset();
        check("tmo_rst_err", 8'(err), 8'h00);
        check("tmo_rst_busy", 8'(busy), 8'h00);
`else
        tick(100);
        check("notmo_req", 8'(req), 8'h01);
        check("notmo_err", 8'(err), 8'h00);
        ack[0] = 1'b1;
        wait_req_low("notmo_rel");
        ack[0] = 1'b0;
        wait_idle("notmo_idle");
        check("notmo_step", 8'(step), 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
